// File: rtl/arm_pkg.sv
// Shared ARM condition-code and NZCV flag definitions.
package arm_pkg;

  localparam int unsigned FLAGS_W = 4;
  localparam int unsigned COND_W  = 4;

  typedef logic [FLAGS_W-1:0] flags_t;

  localparam int unsigned FLAG_V = 0;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_N = 3;

  localparam logic [COND_W-1:0] COND_EQ = 4'b0000;
  localparam logic [COND_W-1:0] COND_NE = 4'b0001;
  localparam logic [COND_W-1:0] COND_CS = 4'b0010;
  localparam logic [COND_W-1:0] COND_CC = 4'b0011;
  localparam logic [COND_W-1:0] COND_MI = 4'b0100;
  localparam logic [COND_W-1:0] COND_PL = 4'b0101;
  localparam logic [COND_W-1:0] COND_VS = 4'b0110;
  localparam logic [COND_W-1:0] COND_VC = 4'b0111;
  localparam logic [COND_W-1:0] COND_HI = 4'b1000;
  localparam logic [COND_W-1:0] COND_LS = 4'b1001;
  localparam logic [COND_W-1:0] COND_GE = 4'b1010;
  localparam logic [COND_W-1:0] COND_LT = 4'b1011;
  localparam logic [COND_W-1:0] COND_GT = 4'b1100;
  localparam logic [COND_W-1:0] COND_LE = 4'b1101;
  localparam logic [COND_W-1:0] COND_AL = 4'b1110;
  localparam logic [COND_W-1:0] COND_NV = 4'b1111;

endpackage

// File: rtl/cond_eval.sv
// Combinational ARM condition evaluator against an NZCV flag vector.
module cond_eval
  import arm_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       pass
);

  logic n, z, c, v;

  always_comb begin
    n    = flags[FLAG_N];
    z    = flags[FLAG_Z];
    c    = flags[FLAG_C];
    v    = flags[FLAG_V];
    pass = 1'b0;
    case (cond)
      COND_EQ: pass = z;
      COND_NE: pass = ~z;
      COND_CS: pass = c;
      COND_CC: pass = ~c;
      COND_MI: pass = n;
      COND_PL: pass = ~n;
      COND_VS: pass = v;
      COND_VC: pass = ~v;
      COND_HI: pass = c & ~z;
      COND_LS: pass = ~c | z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = ~z & (n == v);
      COND_LE: pass = z | (n != v);
      COND_AL: pass = 1'b1;
      COND_NV: pass = 1'b0;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_flags_unit.sv
// Committed NZCV register with EX condition check and zero-cycle ID bypass.
module cond_flags_unit
  import arm_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ex_valid_in,
  input  logic [3:0] ex_cond_in,
  input  logic       ex_s_in,
  input  logic [3:0] alu_flags_in,
  input  logic [3:0] id_cond_in,
  input  logic       stall_in,
  input  logic       flush_in,
  output logic [3:0] flags_out,
  output logic       carry_out,
  output logic       ex_pass_out,
  output logic       id_pass_out,
  output logic       mem_wen_out
);

  flags_t flags_q, flags_d;
  logic   mem_wen_q, mem_wen_d;
  logic   ex_cond_pass;
  logic   flag_we;

  cond_eval u_ex_eval (
    .cond  (ex_cond_in),
    .flags (flags_q),
    .pass  (ex_cond_pass)
  );

  // flags_d doubles as the bypassed view seen by the ID stage
  cond_eval u_id_eval (
    .cond  (id_cond_in),
    .flags (flags_d),
    .pass  (id_pass_out)
  );

  always_comb begin
    ex_pass_out = ex_valid_in & ~flush_in & ex_cond_pass;
    flag_we     = ex_pass_out & ex_s_in & ~stall_in;
    flags_d     = flags_q;
    mem_wen_d   = mem_wen_q;
    if (flag_we) begin
      flags_d = alu_flags_in;
    end
    if (flush_in) begin
      mem_wen_d = 1'b0;
    end else if (!stall_in) begin
      mem_wen_d = ex_pass_out;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q   <= '0;
      mem_wen_q <= 1'b0;
    end else begin
      flags_q   <= flags_d;
      mem_wen_q <= mem_wen_d;
    end
  end

  assign flags_out   = flags_q;
  assign carry_out   = flags_q[FLAG_C];
  assign mem_wen_out = mem_wen_q;

endmodule

// File: tb/tb_cond_flags_unit.sv
// Randomized self-checking bench for cond_flags_unit against a behavioural model.
module tb_cond_flags_unit;

  logic       clk;
  logic       rst_n;
  logic       ex_valid_in;
  logic [3:0] ex_cond_in;
  logic       ex_s_in;
  logic [3:0] alu_flags_in;
  logic [3:0] id_cond_in;
  logic       stall_in;
  logic       flush_in;
  logic [3:0] flags_out;
  logic       carry_out;
  logic       ex_pass_out;
  logic       id_pass_out;
  logic       mem_wen_out;

  int unsigned n_checks = 0;
  int unsigned n_bad    = 0;

  logic [3:0] m_flags;
  logic       m_wen;

  cond_flags_unit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ex_valid_in  (ex_valid_in),
    .ex_cond_in   (ex_cond_in),
    .ex_s_in      (ex_s_in),
    .alu_flags_in (alu_flags_in),
    .id_cond_in   (id_cond_in),
    .stall_in     (stall_in),
    .flush_in     (flush_in),
    .flags_out    (flags_out),
    .carry_out    (carry_out),
    .ex_pass_out  (ex_pass_out),
    .id_pass_out  (id_pass_out),
    .mem_wen_out  (mem_wen_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Conditions come in pairs: even code tests a predicate, odd code its negation.
  function automatic logic ref_cond(input logic [3:0] cc, input logic [3:0] f);
    int n, z, c, v, base;
    n = int'(f[3]); z = int'(f[2]); c = int'(f[1]); v = int'(f[0]);
    if (cc == 4'd14) return 1'b1;
    if (cc == 4'd15) return 1'b0;
    case (int'(cc) / 2)
      0: base = z;
      1: base = c;
      2: base = n;
      3: base = v;
      4: base = (c == 1 && z == 0) ? 1 : 0;
      5: base = (n == v) ? 1 : 0;
      default: base = (z == 0 && n == v) ? 1 : 0;
    endcase
    if (cc[0]) base = 1 - base;
    return base != 0;
  endfunction

  // One clock: drive at negedge, check combinational outputs, step model at posedge.
  task automatic run_cycle(input logic v, input logic [3:0] c, input logic s,
                           input logic [3:0] a, input logic [3:0] ic,
                           input logic st, input logic fl);
    logic exp_ex, we, exp_id;
    ex_valid_in  = v;
    ex_cond_in   = c;
    ex_s_in      = s;
    alu_flags_in = a;
    id_cond_in   = ic;
    stall_in     = st;
    flush_in     = fl;
    #1;
    exp_ex = v && !fl && ref_cond(c, m_flags);
    we     = exp_ex && s && !st;
    exp_id = ref_cond(ic, we ? a : m_flags);
    check("ex_pass", 32'(ex_pass_out), 32'(exp_ex));
    check("id_pass", 32'(id_pass_out), 32'(exp_id));
    check("carry",   32'(carry_out),   32'(m_flags[1]));
    @(posedge clk);
    if (we) m_flags = a;
    if (fl) m_wen = 1'b0;
    else if (!st) m_wen = exp_ex;
    #1;
    check("flags",   32'(flags_out),   32'(m_flags));
    check("mem_wen", 32'(mem_wen_out), 32'(m_wen));
    @(negedge clk);
  endtask

  // Async reset pulse placed just after a rising edge, released at the next falling edge.
  task automatic mid_reset(input string tag);
    #2;
    rst_n = 1'b0;
    #1;
    m_flags = 4'b0000;
    m_wen   = 1'b0;
    check({tag, "_flags"},   32'(flags_out),   32'(4'b0000));
    check({tag, "_mem_wen"}, 32'(mem_wen_out), 32'(1'b0));
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [3:0] rc, ra, ric;
    rst_n = 1'b0;
    ex_valid_in = 1'b0; ex_cond_in = 4'd0; ex_s_in = 1'b0; alu_flags_in = 4'd0;
    id_cond_in = 4'd0; stall_in = 1'b0; flush_in = 1'b0;
    m_flags = 4'b0000;
    m_wen   = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_flags",   32'(flags_out),   32'(4'b0000));
    check("rst_mem_wen", 32'(mem_wen_out), 32'(1'b0));
    rst_n = 1'b1;

    // Reset state: every ID condition against all-zero flags
    id_cond_in = 4'b1110; #1;
    check("rst_id_al", 32'(id_pass_out), 32'(1'b1));
    id_cond_in = 4'b0000; #1;
    check("rst_id_eq", 32'(id_pass_out), 32'(1'b0));
    @(negedge clk);
    for (int i = 0; i < 16; i++) run_cycle(1'b0, 4'd0, 1'b0, 4'd0, 4'(i), 1'b0, 1'b0);

    // AL write of Z with same-cycle EQ bypass
    run_cycle(1'b1, 4'b1110, 1'b1, 4'b0100, 4'b0000, 1'b0, 1'b0);
    check("byp_flags", 32'(flags_out),   32'(4'b0100));
    check("byp_wen",   32'(mem_wen_out), 32'(1'b1));

    // Failed NE leaves flags alone
    run_cycle(1'b1, 4'b0001, 1'b1, 4'b1000, 4'b0001, 1'b0, 1'b0);
    check("ne_flags", 32'(flags_out),   32'(4'b0100));
    check("ne_wen",   32'(mem_wen_out), 32'(1'b0));

    // Stall holds for two cycles, then the write lands
    run_cycle(1'b1, 4'b1110, 1'b1, 4'b0010, 4'b0010, 1'b1, 1'b0);
    run_cycle(1'b1, 4'b1110, 1'b1, 4'b0010, 4'b0010, 1'b1, 1'b0);
    check("stall_hold", 32'(flags_out), 32'(4'b0100));
    run_cycle(1'b1, 4'b1110, 1'b1, 4'b0010, 4'b0010, 1'b0, 1'b0);
    check("stall_flags", 32'(flags_out), 32'(4'b0010));
    check("stall_carry", 32'(carry_out), 32'(1'b1));

    // Flush beats stall
    run_cycle(1'b1, 4'b1110, 1'b1, 4'b1111, 4'b0010, 1'b1, 1'b1);
    check("flush_flags", 32'(flags_out),   32'(4'b0010));
    check("flush_wen",   32'(mem_wen_out), 32'(1'b0));

    // Load 1111 then reset mid-cycle
    ex_valid_in = 1'b1; ex_cond_in = 4'b1110; ex_s_in = 1'b1; alu_flags_in = 4'b1111;
    stall_in = 1'b0; flush_in = 1'b0;
    @(posedge clk);
    m_flags = 4'b1111;
    m_wen   = 1'b1;
    #1;
    check("pre_rst_flags", 32'(flags_out), 32'(4'b1111));
    mid_reset("async_rst");

    // Randomized traffic with occasional async resets
    for (int i = 0; i < 400; i++) begin
      rc  = 4'($urandom_range(0, 15));
      ra  = 4'($urandom_range(0, 15));
      ric = 4'($urandom_range(0, 15));
      run_cycle(1'($urandom_range(0, 3) != 0), rc, 1'($urandom_range(0, 1)), ra, ric,
                1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 6) == 0));
      if ($urandom_range(0, 49) == 0) begin
        @(posedge clk);
        if (!flush_in && !stall_in && ex_valid_in && ref_cond(ex_cond_in, m_flags) && ex_s_in)
          m_flags = alu_flags_in;
        mid_reset("rand_rst");
      end
    end

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
